spi_rx_frame_ctrl: RTL and testbench

//  Sequences an external SPI shift-register deserializer for the receiver's SPI slave port.
//  - Synchronizes raw sck/cs_n/mosi into clk and detects the sample edge and cs_n edges.
//  - Strobes the deserializer and counts bits per word.
//  - Captures each completed DW-bit word into a one-entry holding register.
//  - Hands words to the downstream register/config logic via valid/ready, with frame and error status.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_edge_sync.sv | 39 +++
 rtl/spi_rx_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_rx_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI receive frame controller.
//   spi_rx_state_t  : frame sequencer states
//   sample_on_rise  : true when the sampling sck edge is the rising edge
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    LATCH,
    DONE
  } spi_rx_state_t;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge detection.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : raw asynchronous input
//   dout     : synchronized level (last synchronizer stage)
//   rise     : 1-clk pulse when dout has just gone 0->1
//   fall     : 1-clk pulse when dout has just gone 1->0
module spi_edge_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  // Edges compare the last stage with its one-cycle-old copy, so data taken
  // from dout of a sibling instance lines up with these strobes.
  assign dout = sync[STAGES-1];
  assign rise = dout & ~hist;
  assign fall = ~dout & hist;

endmodule

// File: rtl/spi_rx_frame_ctrl.sv
// Sequences an external SPI deserializer for the receiver's slave port.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   sck, cs_n, mosi    : raw asynchronous SPI pins
//   mosi_s             : synchronized mosi, aligned with sck_sample_edge
//   sck_sample_edge    : strobe to deserializer, shift mosi_s (frame active only)
//   cs_n_falling_edge  : strobe to deserializer, clear shift register
//   des_data           : deserializer parallel output
//   rx_data/rx_first   : captured word and first-in-frame flag
//   rx_valid/rx_ready  : holding-register handshake
//   frame_active       : frame in progress
//   frame_done/err     : end-of-frame pulse, error if partial word
//   overrun/overrun_clr: sticky dropped-word flag and its clear
module spi_rx_frame_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          mosi_s,
  output logic          sck_sample_edge,
  output logic          cs_n_falling_edge,
  input  logic [DW-1:0] des_data,
  output logic [DW-1:0] rx_data,
  output logic          rx_first,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          frame_active,
  output logic          frame_done,
  output logic          frame_err,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam int unsigned    CW    = $clog2(DW);
  localparam logic [CW-1:0]  LAST  = CW'(DW - 1);
  localparam int unsigned    FLUSH = SYNC_STAGES + 1;
  localparam logic           RISE  = sample_on_rise(CPOL, CPHA);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck), .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic sample_edge;
  assign sample_edge       = RISE ? sck_rise : sck_fall;
  assign cs_n_falling_edge = cs_fall;

  spi_rx_state_t state, state_next;
  logic [CW-1:0] bit_cnt;
  logic          first_flag;
  logic          cnt_inc, cnt_clr, frame_start, load_slot;
  logic          capture;

  // A reset taken mid-frame leaves cs_n low; its reset value of 1 would then
  // look like a fresh falling edge. Frames are only armed once the chain has
  // flushed after reset and cs_n is genuinely seen high.
  logic [FLUSH-1:0] flush;
  logic             armed;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;
    frame_start     = 1'b0;
    load_slot       = 1'b0;
    sck_sample_edge = 1'b0;
    frame_active    = 1'b0;
    frame_done      = 1'b0;
    frame_err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_next  = ACTIVE;
          cnt_clr     = 1'b1;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        frame_active    = 1'b1;
        sck_sample_edge = sample_edge;
        if (sample_edge) begin
          if (bit_cnt == LAST) begin
            cnt_clr    = 1'b1;
            state_next = LATCH;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        if (cs_rise) state_next = DONE;
      end
      LATCH: begin
        frame_active = 1'b1;
        load_slot    = 1'b1;
        state_next   = cs_rise ? DONE : ACTIVE;
      end
      DONE: begin
        frame_done = 1'b1;
        frame_err  = (bit_cnt != '0);
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture = load_slot && (!rx_valid || rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      first_flag <= 1'b0;
      rx_data    <= '0;
      rx_first   <= 1'b0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      flush      <= '0;
      armed      <= 1'b0;
    end else begin
      flush <= {flush[FLUSH-2:0], 1'b1};
      if (flush[FLUSH-1] && cs_s) armed <= 1'b1;

      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;

      if (frame_start) first_flag <= 1'b1;
      else if (capture) first_flag <= 1'b0;

      if (capture) begin
        rx_data  <= des_data;
        rx_first <= first_flag;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (load_slot && !capture) overrun <= 1'b1;
      else if (overrun_clr)      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// Self-checking bench: four instances (SPI modes 0..3) share one mosi/cs_n
// stimulus; each mode gets its own sck so that every mode samples at the same
// instant. An event-scheduled model predicts the handshake outputs.
module tb_spi_rx_frame_ctrl;

  localparam int DW   = 16;
  localparam int SYNC = 2;
  localparam int NM   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, cs_n = 1'b1, mosi = 1'b0, rx_ready = 1'b1, overrun_clr = 1'b0;
  logic act0 = 1'b0, act1 = 1'b0;  // active phase for CPHA=0 / CPHA=1 sck
  logic [NM-1:0] sck_v, mosi_s_v, sse_v, csf_v, rx_first_v, rx_valid_v;
  logic [NM-1:0] fa_v, fd_v, fe_v, ovr_v;
  logic [NM-1:0][DW-1:0] rx_data_v;

  for (genvar m = 0; m < NM; m++) begin : g_dut
    localparam bit P = (m / 2) == 1;
    localparam bit H = (m % 2) == 1;
    logic [DW-1:0] des;
    assign sck_v[m] = P ^ (H ? act1 : act0);
    // external deserializer, MSB first
    always @(posedge clk)
      if (rst || csf_v[m]) des <= '0;
      else if (sse_v[m])   des <= {des[DW-2:0], mosi_s_v[m]};
    spi_rx_frame_ctrl #(.DW(DW), .CPOL(P), .CPHA(H), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .sck(sck_v[m]), .cs_n(cs_n), .mosi(mosi),
      .mosi_s(mosi_s_v[m]), .sck_sample_edge(sse_v[m]), .cs_n_falling_edge(csf_v[m]),
      .des_data(des), .rx_data(rx_data_v[m]), .rx_first(rx_first_v[m]),
      .rx_valid(rx_valid_v[m]), .rx_ready(rx_ready), .frame_active(fa_v[m]),
      .frame_done(fd_v[m]), .frame_err(fe_v[m]), .overrun(ovr_v[m]),
      .overrun_clr(overrun_clr)
    );
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s mode%0d: got %h expected %h at t=%0t", name, m, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Events keyed by the clock edge at which their effect becomes visible.
  int cyc = 0;
  logic [DW-1:0] word_val[int];
  bit            end_ev[int];
  bit            start_ev[int];
  logic m_v = 0, m_first = 0, m_ovr = 0, m_fa = 0, m_fp = 0, m_done = 0, m_err = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk) begin
    bit set;
    cyc++;
    m_done = 0; m_err = 0; set = 0;
    if (rst) begin
      m_v = 0; m_first = 0; m_ovr = 0; m_fa = 0; m_fp = 0; m_data = '0;
    end else begin
      if (start_ev.exists(cyc)) begin m_fa = 1; m_fp = 1; end
      if (word_val.exists(cyc)) begin
        if (!m_v || rx_ready) begin
          m_data = word_val[cyc]; m_first = m_fp; m_v = 1; m_fp = 0;
        end else set = 1;
      end else if (m_v && rx_ready) m_v = 0;
      if (set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (end_ev.exists(cyc)) begin m_done = 1; m_err = end_ev[cyc]; m_fa = 0; end
    end
  end

  bit no_sse = 0;
  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      chk("rx_valid", m, 32'(rx_valid_v[m]), 32'(m_v));
      chk("rx_data", m, 32'(rx_data_v[m]), 32'(m_data));
      chk("rx_first", m, 32'(rx_first_v[m]), 32'(m_first));
      chk("overrun", m, 32'(ovr_v[m]), 32'(m_ovr));
      chk("frame_active", m, 32'(fa_v[m]), 32'(m_fa));
      chk("frame_done", m, 32'(fd_v[m]), 32'(m_done));
      chk("frame_err", m, 32'(fe_v[m]), 32'(m_err));
      if (no_sse) chk("sse_idle", m, 32'(sse_v[m]), 32'd0);
    end
  end

  int done_cnt = 0;
  logic done_err_last = 0;
  always @(negedge clk) if (fd_v[0]) begin done_cnt++; done_err_last = fe_v[0]; end

  // ---------------- stimulus ----------------
  bit live = 1, rand_hs = 0;
  int fbits = 0;
  logic [DW-1:0] shreg = '0;

  task automatic tick();
    @(posedge clk); #1;
    if (rand_hs) begin
      rx_ready    = $urandom_range(0, 3) != 0;
      overrun_clr = $urandom_range(0, 15) == 0;
    end
  endtask

  task automatic cs_low();
    tick(); cs_n = 0;
    if (live) start_ev[cyc + SYNC + 1] = 1;
    fbits = 0;
    repeat (3) tick();
  endtask

  // Bit period of 8 clocks; every mode samples at phase 4.
  task automatic send_bits(input logic [31:0] val, input int n, input int tail);
    for (int i = n - 1; i >= 0; i--) begin
      logic b;
      b = val[i];
      tick(); mosi = b; act1 = 1; act0 = 0;
      repeat (3) tick();
      tick(); act1 = 0; act0 = 1;
      fbits++; shreg = {shreg[DW-2:0], b};
      if (live && (fbits % DW) == 0) word_val[cyc + SYNC + 2] = shreg;
      repeat ((i == 0) ? tail : 3) tick();
    end
  endtask

  task automatic sched_end();
    if (live) end_ev[cyc + SYNC + 1] = (fbits % DW) != 0;
  endtask

  task automatic end_frame(input bit early);
    if (early) begin
      tick(); cs_n = 1; sched_end(); repeat (2) tick(); act0 = 0;
    end else begin
      tick(); act0 = 0; repeat (3) tick(); cs_n = 1; sched_end();
    end
    repeat (10) tick();
  endtask

  initial begin
    int n0, d0;
    bit got;
    repeat (4) tick();
    rst = 0;
    repeat (6) tick();
    for (int m = 0; m < NM; m++) chk("reset_valid", m, 32'(rx_valid_v[m]), 32'd0);

    // mode frame of 0xA5C3 with rx_ready=1: latency and 1-clk rx_valid
    d0 = done_cnt;
    cs_low();
    send_bits(32'hA5C3, 16, 0);
    n0 = cyc; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); if (rx_valid_v[0]) got = 1; end
    chk("latency", 0, got ? 32'(cyc - n0) : 32'hFFFF_FFFF, 32'(SYNC + 2));
    chk("t1_data", 0, 32'(rx_data_v[0]), 32'h0000_A5C3);
    chk("t1_first", 0, 32'(rx_first_v[0]), 32'd1);
    tick();
    chk("t1_pulse", 0, 32'(rx_valid_v[0]), 32'd0);
    end_frame(0);
    chk("t1_done", 0, 32'(done_cnt - d0), 32'd1);
    chk("t1_err", 0, 32'(done_err_last), 32'd0);

    // three words with rx_ready low: first held, others dropped
    rx_ready = 0;
    cs_low();
    send_bits(32'h1111, 16, 3); send_bits(32'h2222, 16, 3); send_bits(32'h3333, 16, 3);
    end_frame(0);
    for (int m = 0; m < NM; m++) begin
      chk("ovr_data", m, 32'(rx_data_v[m]), 32'h0000_1111);
      chk("ovr_flag", m, 32'(ovr_v[m]), 32'd1);
    end
    rx_ready = 1; tick();
    overrun_clr = 1; tick(); overrun_clr = 0; tick();
    for (int m = 0; m < NM; m++) chk("ovr_clr", m, 32'(ovr_v[m]), 32'd0);

    // 20-bit frame then a normal frame
    cs_low();
    send_bits(32'h000A_BCDE, 20, 3);
    end_frame(0);
    chk("f20_err", 0, 32'(done_err_last), 32'd1);
    rx_ready = 0;
    cs_low(); send_bits(32'h8001, 16, 3); end_frame(0);
    for (int m = 0; m < NM; m++) begin
      chk("mode_data", m, 32'(rx_data_v[m]), 32'h0000_8001);
      chk("next_first", m, 32'(rx_first_v[m]), 32'd1);
    end
    rx_ready = 1; tick();

    // sck toggling with cs_n high
    no_sse = 1;
    for (int k = 0; k < 6; k++) begin
      act0 = ~act0; act1 = ~act1; repeat (4) tick();
    end
    act0 = 0; act1 = 0; repeat (6) tick();
    no_sse = 0;

    // reset after 7 bits, released with cs_n low
    d0 = done_cnt;
    cs_low();
    send_bits(32'h55, 7, 3);
    rst = 1; live = 0;
    repeat (3) tick();
    rst = 0;
    send_bits(32'h1FF, 9, 3);
    end_frame(0);
    chk("rst_no_done", 0, 32'(done_cnt - d0), 32'd0);
    live = 1;
    rx_ready = 0;
    cs_low(); send_bits(32'h3C5A, 16, 3); end_frame(0);
    chk("post_rst", 0, 32'(rx_data_v[0]), 32'h0000_3C5A);
    rx_ready = 1; tick();

    // cs_n rises during the capture cycle
    d0 = done_cnt; rx_ready = 0;
    cs_low(); send_bits(32'h6E17, 16, 0); end_frame(1);
    chk("late_data", 0, 32'(rx_data_v[0]), 32'h0000_6E17);
    chk("late_done", 0, 32'(done_cnt - d0), 32'd1);
    chk("late_err", 0, 32'(done_err_last), 32'd0);
    rx_ready = 1; tick();

    // randomized frames with random handshake
    rand_hs = 1;
    for (int f = 0; f < 40; f++) begin
      int nw, extra;
      bit early;
      nw = $urandom_range(1, 3);
      extra = $urandom_range(0, 3);
      early = (extra == 0) && ($urandom_range(0, 1) == 1);
      cs_low();
      for (int w = 0; w < nw; w++)
        send_bits(32'($urandom_range(0, 65535)), 16, (w == nw - 1 && early) ? 0 : 3);
      if (extra > 0) send_bits($urandom, extra, 3);
      end_frame(early);
    end
    rand_hs = 0; rx_ready = 1; overrun_clr = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
